// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Lets the instruction-fetch port (I) and the load/store port (D) share one
//   single-port synchronous memory. One transaction is in flight at a time.
//   D has fixed priority. A starvation counter forces an I grant after
//   STARVE_LIMIT back-to-back D grants that were made while I was waiting.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   i_req/i_addr            fetch request, held until i_ready
//   i_ready                 one-cycle grant pulse for I
//   i_rvalid/i_rdata        fetch read-data return
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request, held until d_ready
//   d_ready                 one-cycle grant pulse for D
//   d_rvalid/d_rdata        load read-data return
//   mem_en/we/be/addr/wdata registered memory command
//   mem_rdata               memory read data, valid MEM_LATENCY cycles after mem_en
module mem_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be >= 1");
    end

    localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;        // 1 = D owns the transaction
    logic                owner_we_q, owner_we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;

    logic starved;
    logic d_wins;

    // I is forced only while it is actually waiting and the limit is reached.
    assign starved = (starve_q == STV_W'(STARVE_LIMIT));
    assign d_wins  = d_req && !(i_req && starved);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_we_d  = owner_we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d  = S_ISSUE;
                    mem_en_d = 1'b1;
                    cnt_d    = CNT_W'(MEM_LATENCY);
                    if (d_wins) begin
                        owner_d     = 1'b1;
                        owner_we_d  = d_we;
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        d_ready_d   = 1'b1;
                        // Count only D grants that bypassed a waiting I.
                        if (!i_req)
                            starve_d = '0;
                        else if (!starved)
                            starve_d = starve_q + STV_W'(1);
                    end else begin
                        owner_d     = 1'b0;
                        owner_we_d  = 1'b0;
                        mem_be_d    = 4'hF;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        i_ready_d   = 1'b1;
                        starve_d    = '0;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q - CNT_W'(1);
                // Stores expect no data back, so they skip the wait.
                state_d = owner_we_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            owner_we_q  <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_we_q  <= owner_we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    logic data_back;
    assign data_back = (state_q == S_WAIT) && (cnt_q == '0) && !owner_we_q;

    assign i_rvalid  = data_back && !owner_q;
    assign d_rvalid  = data_back &&  owner_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share the stimulus:
// u_a (MEM_LATENCY=1, a_* outputs) and u_b (MEM_LATENCY=3, b_* outputs).
module tb_mem_arbiter;

    localparam int AW = 30;

    logic          clk, reset_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata, mem_rdata;

    logic          a_i_ready, a_i_rvalid, a_d_ready, a_d_rvalid, a_mem_en, a_mem_we;
    logic [31:0]   a_i_rdata, a_d_rdata, a_mem_wdata;
    logic [3:0]    a_mem_be;
    logic [AW-1:0] a_mem_addr;
    logic          b_i_ready, b_i_rvalid, b_d_ready, b_d_rvalid, b_mem_en, b_mem_we;
    logic [31:0]   b_i_rdata, b_d_rdata, b_mem_wdata;
    logic [3:0]    b_mem_be;
    logic [AW-1:0] b_mem_addr;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(a_i_ready),
        .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(a_d_ready), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(b_i_ready),
        .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic [9:0] seq;
    logic [9:0] exp_seq;
    int         ng;

    initial begin
        do_reset();
        chk("rst_mem_en",  32'(a_mem_en),   32'd0);
        chk("rst_i_ready", 32'(a_i_ready),  32'd0);
        chk("rst_d_ready", 32'(a_d_ready),  32'd0);
        chk("rst_rvalid",  32'({a_i_rvalid, a_d_rvalid, b_i_rvalid, b_d_rvalid}), 32'd0);

        // Single fetch on the latency-1 instance.
        i_req = 1'b1; i_addr = 'h10;
        tick();
        chk("f_mem_en",   32'(a_mem_en),   32'd1);
        chk("f_mem_we",   32'(a_mem_we),   32'd0);
        chk("f_mem_be",   32'(a_mem_be),   32'hF);
        chk("f_mem_addr", 32'(a_mem_addr), 32'h10);
        chk("f_i_ready",  32'(a_i_ready),  32'd1);
        i_req = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        tick();
        chk("f_i_rvalid", 32'(a_i_rvalid), 32'd1);
        chk("f_i_rdata",  a_i_rdata,       32'hDEADBEEF);
        chk("f_d_rvalid", 32'(a_d_rvalid), 32'd0);
        chk("f_en_low",   32'(a_mem_en),   32'd0);
        tick();
        chk("f_rv_once",  32'(a_i_rvalid), 32'd0);

        // Collision: store on D plus fetch on I in the same cycle.
        do_reset();
        i_req = 1'b1; i_addr = 'h123;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 'h40000; d_wdata = 32'h12345678;
        tick();
        chk("c_d_ready",  32'(a_d_ready),   32'd1);
        chk("c_i_ready",  32'(a_i_ready),   32'd0);
        chk("c_mem_we",   32'(a_mem_we),    32'd1);
        chk("c_mem_be",   32'(a_mem_be),    32'hF);
        chk("c_mem_addr", 32'(a_mem_addr),  32'h40000);
        chk("c_wdata",    a_mem_wdata,      32'h12345678);
        d_req = 1'b0;
        tick();
        chk("c2_d_rvalid", 32'(a_d_rvalid), 32'd0);
        chk("c2_mem_en",   32'(a_mem_en),   32'd0);
        chk("c2_i_ready",  32'(a_i_ready),  32'd0);
        tick();
        chk("c3_i_ready",  32'(a_i_ready),  32'd1);
        chk("c3_mem_addr", 32'(a_mem_addr), 32'h123);
        chk("c3_mem_we",   32'(a_mem_we),   32'd0);
        chk("c3_d_rvalid", 32'(a_d_rvalid), 32'd0);
        i_req = 1'b0;

        // Zero byte-enable store, then asynchronous reset while mem_en is high.
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 'h7; d_wdata = 32'hA5A5A5A5;
        tick();
        chk("z_mem_en", 32'(a_mem_en), 32'd1);
        chk("z_mem_we", 32'(a_mem_we), 32'd1);
        chk("z_mem_be", 32'(a_mem_be), 32'h0);
        d_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_mem_en",   32'(a_mem_en),   32'd0);
        chk("ar_mem_we",   32'(a_mem_we),   32'd0);
        chk("ar_d_ready",  32'(a_d_ready),  32'd0);
        chk("ar_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("ar_wdata",    a_mem_wdata,     32'd0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("idle_en%0d", k), 32'({a_mem_en, b_mem_en}), 32'd0);
        end

        // Starvation guard: both requesters held continuously.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 'h3;
        i_req = 1'b1; i_addr = 'h9;
        exp_seq = 10'b0111101111;   // bit k = 1 for a D grant, D,D,D,D,I,D,D,D,D,I
        seq = '0;
        ng = 0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            tick();
            if (a_d_ready || a_i_ready) begin
                seq[ng] = a_d_ready;
                ng++;
            end
        end
        chk("stv_count", 32'(ng), 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("stv_g%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        i_req = 1'b0; d_req = 1'b0;

        // Latency 3: load at T, rvalid at T+3, pending fetch granted at T+5.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 'h55;
        tick();
        chk("l_mem_en",  32'(b_mem_en),  32'd1);
        chk("l_d_ready", 32'(b_d_ready), 32'd1);
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 'h77;
        tick();
        chk("l1_rvalid", 32'({b_d_rvalid, b_i_rvalid}), 32'd0);
        chk("l1_iready", 32'(b_i_ready), 32'd0);
        tick();
        chk("l2_rvalid", 32'({b_d_rvalid, b_i_rvalid}), 32'd0);
        mem_rdata = 32'hCAFEF00D;
        tick();
        chk("l3_d_rvalid", 32'(b_d_rvalid), 32'd1);
        chk("l3_d_rdata",  b_d_rdata,       32'hCAFEF00D);
        chk("l3_i_rvalid", 32'(b_i_rvalid), 32'd0);
        chk("l3_i_ready",  32'(b_i_ready),  32'd0);
        tick();
        chk("l4_d_rvalid", 32'(b_d_rvalid), 32'd0);
        chk("l4_i_ready",  32'(b_i_ready),  32'd0);
        tick();
        chk("l5_i_ready",  32'(b_i_ready),  32'd1);
        chk("l5_mem_addr", 32'(b_mem_addr), 32'h77);
        i_req = 1'b0;

        // Reset during WAIT: the load is dropped, a held fetch is granted afresh.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 'h66;
        tick();
        chk("rw_d_ready", 32'(b_d_ready), 32'd1);
        d_req = 1'b0;
        tick();
        reset_n = 1'b0;
        i_req = 1'b1; i_addr = 'h2A;
        mem_rdata = 32'h11111111;
        #1;
        chk("rw1_rvalid", 32'(b_d_rvalid), 32'd0);
        tick();
        chk("rw2_rvalid", 32'(b_d_rvalid), 32'd0);
        tick();
        chk("rw3_rvalid", 32'(b_d_rvalid), 32'd0);
        chk("rw3_iready", 32'(b_i_ready),  32'd0);
        reset_n = 1'b1;
        tick();
        chk("rw4_i_ready",  32'(b_i_ready),  32'd1);
        chk("rw4_mem_addr", 32'(b_mem_addr), 32'h2A);
        chk("rw4_d_rvalid", 32'(b_d_rvalid), 32'd0);
        i_req = 1'b0;
        tick();
        chk("rw5_i_ready",  32'(b_i_ready),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, synchronous unified memory between the instruction-fetch port (I) and the load/store port (D) of the core. This is the path toward a unified-memory, multi-cycle core.
- Arbitrates one transaction at a time and drives the memory control signals.
- Times read-data return and steers it to the owning requester.
- D has fixed priority, with a starvation guard that forces periodic I grants.

Parameters:
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; must be >=1 (0 is an elaboration error).
- STARVE_LIMIT, 4, consecutive D grants allowed while i_req is pending before I is forced.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_ready.
- i_addr  in  ADDR_W  fetch word address.
- i_ready  out  1  one-cycle grant pulse for I.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request; held with its fields until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle grant pulse for D.
- d_rvalid  out  1  load read data valid.
- d_rdata  out  32  load read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid exactly MEM_LATENCY cycles after mem_en.

Behaviour:
- State machine: IDLE, ISSUE, WAIT. The I/D owner flag, owner_we flag, latency counter and starvation counter are all registers.
- Registered outputs: mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_ready, d_ready.
- Combinational outputs:
  - i_rdata = d_rdata = mem_rdata, ungated.
  - x_rvalid = (state==WAIT && cnt==0 && !owner_we && owner==x).
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; all counters are cleared.
  - All registered outputs become 0, which forces i_rvalid and d_rvalid to 0.
  - Any in-flight transaction is discarded with no rvalid; requests still pending after release are re-arbitrated from scratch.
- IDLE:
  - No request: stay in IDLE, mem_en=0.
  - Any request: pick a winner and go to ISSUE on the same edge, loading mem_* from the winner, setting winner_ready=1, latching owner/owner_we, and loading cnt=MEM_LATENCY.
  - For an I grant: mem_we=0, mem_be=4'hF, mem_wdata=0.
- Winner selection:
  - D wins if d_req && !(i_req && starve==STARVE_LIMIT); otherwise I wins.
  - starve increments on a D grant while i_req=1.
  - starve clears on an I grant, or on any grant with i_req=0.
  - starve saturates at STARVE_LIMIT.
- ISSUE (exactly 1 cycle, mem_en=1, ready pulse high):
  - Next edge: mem_en, mem_we and ready return to 0, and cnt decrements.
  - Store: next state is IDLE; no rvalid is ever produced.
  - Load or fetch: next state is WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==0, rvalid is asserted for exactly one cycle to the owner, and the next state is IDLE.
- Timing:
  - Request seen in IDLE at cycle C: mem_en and ready in C+1; rvalid in C+1+MEM_LATENCY; IDLE at C+2+MEM_LATENCY.
  - Back-to-back reads: one per MEM_LATENCY+2 cycles. Back-to-back stores: one per 2 cycles.
- Requesters must hold req and their fields stable until ready. Behaviour is undefined if a requester drops req before ready.
- A new request arriving in ISSUE or WAIT is ignored until IDLE.
- d_we=1 with d_be=0 is issued normally: mem_en=1, mem_we=1, mem_be=0. It is a no-op write, not an error.
- Both requests in the same IDLE cycle: resolved by the winner-selection rule only; the loser keeps waiting.

Test Plan:
- Reset and idle: reset_n=0 mid-simulation → all outputs 0 immediately, without waiting for a clock edge. After release with no requests → mem_en stays 0 for 10 cycles.
- Single fetch, MEM_LATENCY=1: i_req=1, i_addr=0x10 at cycle 0.
  - Cycle 1: mem_en=1, mem_we=0, mem_addr=0x10, i_ready=1.
  - Cycle 2: mem_rdata=0xDEADBEEF → i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
- Collision: i_req and a d_req store (d_addr=0x40000, d_wdata=0x12345678, d_be=4'hF) in the same cycle.
  - Cycle 1: d_ready=1, mem_we=1, mem_be=F; no d_rvalid.
  - Cycle 3: I granted (i_ready=1, mem_addr=i_addr).
- Starvation, STARVE_LIMIT=4: d_req (loads) and i_req held continuously, requesters re-asserting immediately → grant sequence D,D,D,D,I,D,D,D,D,I.
- Latency, MEM_LATENCY=3: load issued at cycle T → d_rvalid only at T+3. Next grant at T+5. No rvalid pulse at T+1 or T+2.
- Reset mid-WAIT, MEM_LATENCY=3: reset_n low at T+1 → no rvalid at T+3. After release with i_req held → a fresh grant occurs 1 cycle after the first post-reset edge.
